add_round_key: RTL and testbench
================================

ADD_ROUND_KEY -- requirements
Module: add_round_key

Interface
REQ-001 The block SHALL have parameter ROUNDS, default 10, giving the number of AES-128 rounds and the highest legal round index.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port valid, input, 1 bit: request; held high until done is seen.
REQ-005 The block SHALL have port round, input, 4 bits: round-key index 0..ROUNDS, sampled with valid.
REQ-006 The block SHALL have port cipher_key, input, 128 bits: AES-128 cipher key; bits 127:120 = key byte 0.
REQ-007 The block SHALL have port state_in, input, 128 bits: AES state; bits 127:120 = byte 0, column-major.
REQ-008 The block SHALL have port state_out, output, 128 bits: state_in XOR selected round key.
REQ-009 The block SHALL have port done, output, 1 bit: result valid; handshake acknowledge.

Function
REQ-010 The FSM SHALL have states IDLE, EXPAND and DONE.
REQ-011 In IDLE with valid=1, the block SHALL, on that edge, latch round, cipher_key and state_in, load the working key with cipher_key, clear the key counter and enter EXPAND.
REQ-012 In EXPAND with counter /= latched round, the block SHALL apply one FIPS-197 key-schedule step per cycle (RotWord, SubWord, Rcon[counter+1], word XOR chain) and increment the counter.
REQ-013 In EXPAND with counter = latched round, the block SHALL register state_out = latched state XOR working key, set done=1 and enter DONE.
REQ-014 Latency SHALL be exactly round+1 cycles from the accepting edge to the edge that sets done (round 0 -> 1 cycle, round 10 -> 11 cycles).
REQ-015 In DONE, done SHALL stay 1 while valid=1; when valid is sampled 0, the block SHALL clear done and return to IDLE (four-phase handshake).
REQ-016 Inputs SHALL be ignored outside IDLE; changes to round, cipher_key or state_in during an operation SHALL NOT affect the result.
REQ-017 A round input greater than ROUNDS SHALL be saturated to ROUNDS when latched.
REQ-018 state_out SHALL hold its last result until the next completion; it SHALL NOT change in IDLE or EXPAND.
REQ-019 A valid held continuously high SHALL yield exactly one operation; a new request requires valid to go low for at least one cycle.

Reset
REQ-020 With rst=0 at a rising edge, the FSM SHALL enter IDLE, done SHALL become 0, state_out SHALL become 0, and the counter and working key SHALL be cleared.
REQ-021 Reset asserted mid-operation SHALL abort that operation with no done pulse; reset SHALL take priority over valid.

Configuration
REQ-022 With macro ADD_ROUND_KEY_RK_OUT_EN defined, the block SHALL add output round_key (128 bits), registered with state_out, carrying the round key used; without the macro, the port and its register SHALL be absent and behaviour otherwise identical.

Structure
REQ-023 Shared package aes_pkg SHALL hold the 128-bit state/key type, the ROUNDS default, the 256-entry S-box function and the Rcon table (01,02,04,08,10,20,40,80,1b,36).
REQ-024 One combinational sub-module, aes_key_step (inputs: previous round key, Rcon byte; output: next round key), SHALL implement REQ-012.

Verification
REQ-025 Round 0: key 2b7e151628aed2a6abf7158809cf4f3c, state_in 3243f6a8885a308d313198a2e0370734 -> done 1 cycle after accept; state_out 193de3bea0f4e22b9ac68d2ae9f84808.
REQ-026 Round 1: same key, state_in 0 -> state_out a0fafe1788542cb123a339392a6c7605 after 2 cycles.
REQ-027 Round 10: same key, state_in 0 -> state_out d014f9a8c9ee2589e13f0cc8b6630ca6 after 11 cycles; round=15 gives the same result and latency.
REQ-028 Handshake: hold valid high 20 cycles -> exactly one operation, done stays 1 until valid drops; done falls 1 cycle after valid is sampled low.
REQ-029 Reset: assert rst=0 at cycle 5 of a round-10 operation -> done remains 0, state_out=0, FSM in IDLE; next request completes normally.
REQ-030 With ADD_ROUND_KEY_RK_OUT_EN defined: the round-1 case gives round_key = a0fafe1788542cb123a339392a6c7605.

Source files
------------

// File: rtl/aes_pkg.sv
// AES-128 shared types, constants, S-box and Rcon helpers.
// Used by add_round_key and its key-schedule step.
package aes_pkg;

  typedef logic [127:0] blk_t;

  localparam int ROUNDS_DEF = 10;

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = 11'd2047 - {b, 3'b000};
    return SBOX_TBL[idx -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: previous round key to next.
// Purely combinational.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key_prev,
  input  logic [7:0]   rcon_b,
  output logic [127:0] key_next
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, tmp;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_prev;

  assign rot = {w3[23:0], w3[31:24]};

  assign tmp = {sbox(rot[31:24]) ^ rcon_b,
                sbox(rot[23:16]),
                sbox(rot[15:8]),
                sbox(rot[7:0])};

  assign n0 = w0 ^ tmp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_next = {n0, n1, n2, n3};

endmodule

// File: rtl/add_round_key.sv
// AddRoundKey with on-the-fly AES-128 key expansion, 4-phase handshake.
// ADD_ROUND_KEY_RK_OUT_EN adds the round_key output port.
module add_round_key
  import aes_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic [3:0]   round,
  input  logic [127:0] cipher_key,
  input  logic [127:0] state_in,
`ifdef ADD_ROUND_KEY_RK_OUT_EN
  output logic [127:0] round_key,
`endif
  output logic [127:0] state_out,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } st_t;

  localparam logic [3:0] RMAX = 4'(ROUNDS);

  st_t        st, st_d;
  logic [3:0] cnt, cnt_d;
  logic [3:0] rnd_q, rnd_d;
  blk_t       key_q, key_d;
  blk_t       dat_q, dat_d;
  blk_t       out_d;
  logic       done_d;
  blk_t       key_nxt;

  aes_key_step u_step (
    .key_prev (key_q),
    .rcon_b   (rcon(cnt + 4'd1)),
    .key_next (key_nxt)
  );

`ifdef ADD_ROUND_KEY_RK_OUT_EN
  blk_t rk_d;

  always_ff @(posedge clk) begin
    if (!rst) round_key <= '0;
    else      round_key <= rk_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      st        <= IDLE;
      cnt       <= '0;
      rnd_q     <= '0;
      key_q     <= '0;
      dat_q     <= '0;
      state_out <= '0;
      done      <= 1'b0;
    end else begin
      st        <= st_d;
      cnt       <= cnt_d;
      rnd_q     <= rnd_d;
      key_q     <= key_d;
      dat_q     <= dat_d;
      state_out <= out_d;
      done      <= done_d;
    end
  end

  always_comb begin
    st_d   = st;
    cnt_d  = cnt;
    rnd_d  = rnd_q;
    key_d  = key_q;
    dat_d  = dat_q;
    out_d  = state_out;
    done_d = done;
`ifdef ADD_ROUND_KEY_RK_OUT_EN
    rk_d   = round_key;
`endif
    unique case (st)
      IDLE: begin
        if (valid) begin
          rnd_d = (round > RMAX) ? RMAX : round;
          key_d = cipher_key;
          dat_d = state_in;
          cnt_d = '0;
          st_d  = EXPAND;
        end
      end
      EXPAND: begin
        if (cnt == rnd_q) begin
          out_d  = dat_q ^ key_q;
          done_d = 1'b1;
`ifdef ADD_ROUND_KEY_RK_OUT_EN
          rk_d   = key_q;
`endif
          st_d   = DONE;
        end else begin
          key_d = key_nxt;
          cnt_d = cnt + 4'd1;
        end
      end
      DONE: begin
        // Hold the result until the requester drops valid.
        if (!valid) begin
          done_d = 1'b0;
          st_d   = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_add_round_key.sv
// Directed self-checking bench for add_round_key.
// Uses FIPS-197 key-expansion vectors for the expected values.
module tb_add_round_key;

  logic         clk;
  logic         rst;
  logic         valid;
  logic [3:0]   round;
  logic [127:0] cipher_key;
  logic [127:0] state_in;
  logic [127:0] state_out;
  logic         done;
`ifdef ADD_ROUND_KEY_RK_OUT_EN
  logic [127:0] round_key;
`endif

  int errs;
  int checks;
  logic [127:0] last_out;

  localparam logic [127:0] KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  add_round_key dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .round      (round),
    .cipher_key (cipher_key),
    .state_in   (state_in),
`ifdef ADD_ROUND_KEY_RK_OUT_EN
    .round_key  (round_key),
`endif
    .state_out  (state_out),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [3:0] rnd,
                        input logic [127:0] st,
                        input logic [127:0] exp_out,
                        input logic [127:0] exp_rk,
                        input int exp_lat);
    int lat;
    @(negedge clk);
    valid      = 1'b1;
    round      = rnd;
    cipher_key = KEY;
    state_in   = st;
    @(negedge clk);
    check({tag, "_hold"}, state_out, last_out);
    round      = 4'd3;
    cipher_key = 128'hdeadbeef_0badf00d_12345678_9abcdef0;
    state_in   = 128'hffff0000_ffff0000_ffff0000_ffff0000;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    check({tag, "_out"}, state_out, exp_out);
`ifdef ADD_ROUND_KEY_RK_OUT_EN
    check({tag, "_rk"}, round_key, exp_rk);
`else
    if (exp_rk === 128'hx) $display("unused");
`endif
    valid = 1'b0;
    @(negedge clk);
    check({tag, "_drop"}, 128'(done), 128'd0);
    last_out = exp_out;
  endtask

  initial begin
    int hi;
    errs       = 0;
    checks     = 0;
    last_out   = '0;
    rst        = 1'b0;
    valid      = 1'b0;
    round      = '0;
    cipher_key = '0;
    state_in   = '0;
    repeat (3) @(negedge clk);
    check("rst_done", 128'(done), 128'd0);
    check("rst_out", state_out, 128'd0);
    rst = 1'b1;

    run_op("r0", 4'd0, 128'h3243f6a8885a308d313198a2e0370734,
           128'h193de3bea0f4e22b9ac68d2ae9f84808, KEY, 1);
    run_op("r0z", 4'd0, 128'd0, KEY, KEY, 1);
    run_op("r1", 4'd1, 128'd0, RK1, RK1, 2);
    run_op("r2", 4'd2, 128'hffffffff_00000000_ffffffff_00000000,
           RK2 ^ 128'hffffffff_00000000_ffffffff_00000000, RK2, 3);
    run_op("r10", 4'd10, 128'd0, RK10, RK10, 11);
    run_op("r15", 4'd15, 128'd0, RK10, RK10, 11);

    // Valid held for 22 cycles: one op, done high for the last 20.
    @(negedge clk);
    valid      = 1'b1;
    round      = 4'd1;
    cipher_key = KEY;
    state_in   = 128'h0123456789abcdef0123456789abcdef;
    hi = 0;
    repeat (22) begin
      @(negedge clk);
      if (done) hi++;
    end
    check("hs_hi", 128'(hi), 128'd20);
    check("hs_out", state_out,
          RK1 ^ 128'h0123456789abcdef0123456789abcdef);
    valid = 1'b0;
    @(negedge clk);
    check("hs_fall", 128'(done), 128'd0);
    last_out = RK1 ^ 128'h0123456789abcdef0123456789abcdef;

    // Reset in the middle of a round-10 operation.
    @(negedge clk);
    valid    = 1'b1;
    round    = 4'd10;
    state_in = 128'd0;
    repeat (5) @(negedge clk);
    rst   = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mr_done", 128'(done), 128'd0);
    check("mr_out", state_out, 128'd0);
    hi = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) hi++;
    end
    check("mr_quiet", 128'(hi), 128'd0);
    last_out = '0;
    run_op("mr_next", 4'd1, 128'd0, RK1, RK1, 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
